// File: rtl/fast_square_pkg.sv
// Shared definitions for the synthesizer step programmer: word width, default
// parameter values, sequencer state encoding and serializer phases.
package fast_square_pkg;

  localparam int SYNTH_WORD_W = 24;

  localparam int                      DEF_NUM_FREQ_STEPS     = 14;
  localparam logic [SYNTH_WORD_W-1:0] DEF_BASE_WORD          = 24'h0A0001;
  localparam logic [SYNTH_WORD_W-1:0] DEF_STEP_WORD          = 24'h000100;
  localparam int                      DEF_SCLK_DIV           = 4;
  localparam int                      DEF_LOCK_TIMEOUT_TICKS = 50000;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD     = 3'd1;
  localparam logic [STATE_W-1:0] ST_SHIFT    = 3'd2;
  localparam logic [STATE_W-1:0] ST_LATCH    = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOCKWAIT = 3'd4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_LATCH = 2'd2
  } tx_phase_e;

endpackage

// File: rtl/freq_step_programmer_if.sv
// Request, lock-detect, status and 3-wire SPI signals of the step programmer.
interface freq_step_programmer_if;

  logic       freq_step_reset;
  logic       freq_step;
  logic       pll_locked;
  logic       spi_sclk;
  logic       spi_data;
  logic       spi_le;
  logic       busy;
  logic [7:0] step_index;
  logic       lock_timeout;

  modport master (
    output freq_step_reset, freq_step, pll_locked,
    input  spi_sclk, spi_data, spi_le, busy, step_index, lock_timeout
  );

  modport slave (
    input  freq_step_reset, freq_step, pll_locked,
    output spi_sclk, spi_data, spi_le, busy, step_index, lock_timeout
  );

endinterface

// File: rtl/synth_spi_tx.sv
// 3-wire serializer: shifts a 24-bit word MSB first on an idle-low SCLK, then
// pulses LE for SCLK_DIV cycles. abort drops every line low immediately.
module synth_spi_tx
  import fast_square_pkg::*;
#(
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    abort,
  input  logic                    start,
  input  logic [SYNTH_WORD_W-1:0] word,
  output logic                    spi_sclk,
  output logic                    spi_data,
  output logic                    spi_le,
  output logic                    shift_done,
  output logic                    done
);

  localparam int               DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam int               BIT_W    = $clog2(SYNTH_WORD_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SYNTH_WORD_W - 1);

  tx_phase_e               phase;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SYNTH_WORD_W-1:0] shreg;
  logic                    div_wrap;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign shift_done = (phase == TX_SHIFT) && spi_sclk && div_wrap && (bit_cnt == BIT_LAST);
  assign done       = (phase == TX_LATCH) && div_wrap;
  // Data follows the shift register, which only moves on the falling SCLK edge.
  assign spi_data   = (phase == TX_SHIFT) && shreg[SYNTH_WORD_W-1];

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      phase    <= TX_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      spi_sclk <= 1'b0;
      spi_le   <= 1'b0;
    end else begin
      case (phase)
        TX_IDLE: begin
          if (start) begin
            phase    <= TX_SHIFT;
            shreg    <= word;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            spi_sclk <= 1'b0;
          end
        end
        TX_SHIFT: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
          if (div_wrap) begin
            spi_sclk <= ~spi_sclk;
            if (spi_sclk) begin
              if (bit_cnt == BIT_LAST) begin
                phase  <= TX_LATCH;
                spi_le <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[SYNTH_WORD_W-2:0], 1'b0};
              end
            end
          end
        end
        TX_LATCH: begin
          div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
          if (div_wrap) begin
            spi_le <= 1'b0;
            phase  <= TX_IDLE;
          end
        end
        default: phase <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/freq_step_programmer.sv
// Sweep sequencer: tracks the synthesizer step, programs each word over SPI and
// waits for PLL relock, with a one-deep request queue and a sticky timeout flag.
module freq_step_programmer
  import fast_square_pkg::*;
#(
  parameter int                      NUM_FREQ_STEPS     = DEF_NUM_FREQ_STEPS,
  parameter logic [SYNTH_WORD_W-1:0] BASE_WORD          = DEF_BASE_WORD,
  parameter logic [SYNTH_WORD_W-1:0] STEP_WORD          = DEF_STEP_WORD,
  parameter int                      SCLK_DIV           = DEF_SCLK_DIV,
  parameter int                      LOCK_TIMEOUT_TICKS = DEF_LOCK_TIMEOUT_TICKS
) (
  input  logic                 clock,
  input  logic                 reset,
  freq_step_programmer_if.slave bus
);

  localparam int               TO_W      = $clog2(LOCK_TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT_TICKS - 1);
  localparam logic [7:0]       LAST_STEP = 8'(NUM_FREQ_STEPS - 1);

  logic [STATE_W-1:0]      state;
  logic [7:0]              step_index;
  logic [SYNTH_WORD_W-1:0] acc;
  logic                    pending;
  logic                    lock_timeout;
  logic [TO_W-1:0]         lock_cnt;
  logic                    advance;
  logic                    tx_start;
  logic                    tx_shift_done;
  logic                    tx_done;

  // A queued request is served from IDLE exactly like a fresh pulse.
  assign advance  = (state == ST_IDLE) && (bus.freq_step || pending);
  assign tx_start = (state == ST_LOAD);

  assign bus.busy         = !((state == ST_IDLE) && !pending);
  assign bus.step_index   = step_index;
  assign bus.lock_timeout = lock_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      step_index   <= '0;
      acc          <= BASE_WORD;
      pending      <= 1'b0;
      lock_timeout <= 1'b0;
      lock_cnt     <= '0;
    end else if (bus.freq_step_reset) begin
      state        <= ST_LOAD;
      step_index   <= '0;
      acc          <= BASE_WORD;
      pending      <= 1'b0;
      lock_timeout <= 1'b0;
      lock_cnt     <= '0;
    end else begin
      if (bus.freq_step && !advance) begin
        pending <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (advance) begin
            pending <= 1'b0;
            state   <= ST_LOAD;
            if (step_index == LAST_STEP) begin
              step_index <= '0;
              acc        <= BASE_WORD;
            end else begin
              step_index <= step_index + 8'd1;
              acc        <= acc + STEP_WORD;
            end
          end
        end
        ST_LOAD:  state <= ST_SHIFT;
        ST_SHIFT: if (tx_shift_done) state <= ST_LATCH;
        ST_LATCH: begin
          if (tx_done) begin
            state    <= ST_LOCKWAIT;
            lock_cnt <= '0;
          end
        end
        ST_LOCKWAIT: begin
          if (bus.pll_locked) begin
            state <= ST_IDLE;
          end else if (lock_cnt == TO_LAST) begin
            lock_timeout <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  synth_spi_tx #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi_tx (
    .clock      (clock),
    .reset      (reset),
    .abort      (bus.freq_step_reset),
    .start      (tx_start),
    .word       (acc),
    .spi_sclk   (bus.spi_sclk),
    .spi_data   (bus.spi_data),
    .spi_le     (bus.spi_le),
    .shift_done (tx_shift_done),
    .done       (tx_done)
  );

endmodule
